// File: rtl/mac_psum_pkg.sv
// Shared types, default widths and the saturate/truncate helper for the partial-sum accumulator.
package mac_psum_pkg;

  localparam int unsigned DefInWidth  = 27;
  localparam int unsigned DefAccWidth = 40;
  localparam int unsigned DefOutWidth = 32;
  localparam int unsigned DefCntWidth = 4;

  // Widest accumulator the helper supports; callers sign-extend into this width.
  localparam int unsigned MaxAccWidth = 64;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} psum_state_t;

  // Returns {ovf, value}: value is the OUT_WIDTH result sign-extended to MaxAccWidth,
  // ovf flags that acc does not fit in out_width signed bits.
  function automatic logic [MaxAccWidth:0] sat_trunc(input logic signed [MaxAccWidth-1:0] acc,
                                                     input int unsigned out_width,
                                                     input bit sat_en);
    logic signed [MaxAccWidth-1:0] hi;
    logic signed [MaxAccWidth-1:0] lo;
    logic signed [MaxAccWidth-1:0] res;
    logic                          ovf;
    hi  = (MaxAccWidth'(1) <<< (out_width - 1)) - MaxAccWidth'(1);
    lo  = -hi - MaxAccWidth'(1);
    ovf = (acc > hi) || (acc < lo);
    if (sat_en && ovf) begin
      res = acc[MaxAccWidth-1] ? lo : hi;
    end else begin
      res = (acc <<< (MaxAccWidth - out_width)) >>> (MaxAccWidth - out_width);
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/mac_psum_out_reduce.sv
// Combinational ACC_WIDTH -> OUT_WIDTH reduction (clamp or wrap) with overflow detect.
module mac_psum_out_reduce
  import mac_psum_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = DefAccWidth,
  parameter int unsigned OUT_WIDTH = DefOutWidth,
  parameter bit          SAT_EN    = 1'b0
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic signed [OUT_WIDTH-1:0] data_o,
  output logic                        ovf_o
);

  logic [MaxAccWidth:0] res;

  always_comb begin
    res = sat_trunc(MaxAccWidth'(acc_i), OUT_WIDTH, SAT_EN);
  end

  assign data_o = res[OUT_WIDTH-1:0];
  assign ovf_o  = res[MaxAccWidth];

  // Upper bits only repeat the sign of data_o.
  logic unused_res;
  assign unused_res = ^res[MaxAccWidth-1:OUT_WIDTH];

endmodule

// File: rtl/mac_psum_accumulator.sv
// Accumulates a programmable number of reduction beats (plain sum or MSB-first bit-serial)
// and holds the result on a valid/ready port. Define MAC_PSUM_SAT_EN for clamped output.
module mac_psum_accumulator
  import mac_psum_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DefInWidth,
  parameter int unsigned ACC_WIDTH = DefAccWidth,
  parameter int unsigned OUT_WIDTH = DefOutWidth,
  parameter int unsigned CNT_WIDTH = DefCntWidth
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        num_beats,
  input  logic                        bit_serial,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        in_neg,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        busy
`ifdef MAC_PSUM_SAT_EN
  ,
  output logic                        sat_flag
`endif
);

`ifdef MAC_PSUM_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  psum_state_t                 state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]        num_beats_q, num_beats_d;
  logic                        bit_serial_q, bit_serial_d;
  logic signed [ACC_WIDTH-1:0] term;
  logic                        ovf;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    num_beats_d  = num_beats_q;
    bit_serial_d = bit_serial_q;
    term         = ACC_WIDTH'(in_data);
    if (in_neg) begin
      term = -term;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = ACCUM;
          num_beats_d  = num_beats;
          bit_serial_d = bit_serial;
          acc_d        = '0;
          cnt_d        = '0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = (bit_serial_q ? (acc_q <<< 1) : acc_q) + term;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == num_beats_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          // Consume and restart in the same cycle keeps back-to-back jobs at one bubble.
          if (start) begin
            state_d      = ACCUM;
            num_beats_d  = num_beats;
            bit_serial_d = bit_serial;
            acc_d        = '0;
            cnt_d        = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      num_beats_q  <= '0;
      bit_serial_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      num_beats_q  <= num_beats_d;
      bit_serial_q <= bit_serial_d;
    end
  end

  mac_psum_out_reduce #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SAT_EN    (SatEn)
  ) u_out_reduce (
    .acc_i  (acc_q),
    .data_o (out_data),
    .ovf_o  (ovf)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

`ifdef MAC_PSUM_SAT_EN
  assign sat_flag = out_valid & ovf;
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif

endmodule

// File: tb/tb_mac_psum_accumulator.sv
// Directed bench: a default-width and an 8-bit-output accumulator share stimulus and are
// checked against a job-level arithmetic model. Honours MAC_PSUM_SAT_EN.
module tb_mac_psum_accumulator;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [3:0]        num_beats;
  logic              bit_serial;
  logic              in_valid;
  logic signed [26:0] in_data;
  logic              in_neg;
  logic              out_ready;
  logic              in_ready, out_valid, busy;
  logic signed [31:0] out32;
  logic              in_ready8, out_valid8, busy8;
  logic signed [7:0] out8;
`ifdef MAC_PSUM_SAT_EN
  logic              sat_flag, sat_flag8;
`endif

  always #5 clk = ~clk;

  mac_psum_accumulator u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_beats  (num_beats),
    .bit_serial (bit_serial),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_neg     (in_neg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out32),
    .busy       (busy)
`ifdef MAC_PSUM_SAT_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  mac_psum_accumulator #(.OUT_WIDTH(8)) u_dut8 (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_beats  (num_beats),
    .bit_serial (bit_serial),
    .in_valid   (in_valid),
    .in_ready   (in_ready8),
    .in_data    (in_data),
    .in_neg     (in_neg),
    .out_valid  (out_valid8),
    .out_ready  (out_ready),
    .out_data   (out8),
    .busy       (busy8)
`ifdef MAC_PSUM_SAT_EN
    ,
    .sat_flag   (sat_flag8)
`endif
  );

  int     n_cmp = 0;
  int     n_err = 0;
  int     beats[16];
  bit     negs[16];
  longint exp_acc[$];
  int     exp_n[$];
  int     beat_cnt = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint wrap_to(input longint a, input int w);
    return (a <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint sat_to(input longint a, input int w);
    longint lim;
    lim = longint'(1) << (w - 1);
    if (a > lim - 1) return lim - 1;
    if (a < -lim) return -lim;
    return a;
  endfunction

  function automatic longint reduce_to(input longint a, input int w);
`ifdef MAC_PSUM_SAT_EN
    return sat_to(a, w);
`else
    return wrap_to(a, w);
`endif
  endfunction

  // Job-level model: fold the beat list with plain arithmetic, wrap to the accumulator width.
  task automatic push_exp(input int n, input bit serial);
    longint acc;
    longint t;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      t   = negs[i] ? -longint'(beats[i]) : longint'(beats[i]);
      acc = serial ? acc * 2 + t : acc + t;
    end
    exp_acc.push_back(wrap_to(acc, 40));
    exp_n.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input int first, input int step);
    for (int i = 0; i < 16; i++) begin
      beats[i] = first + i * step;
      negs[i]  = 1'b0;
    end
  endtask

  task automatic begin_job(input int n, input bit serial, input bit track);
    start      = 1'b1;
    num_beats  = 4'(n - 1);
    bit_serial = serial;
    if (track) push_exp(n, serial);
    tick();
    start = 1'b0;
  endtask

  task automatic feed_beats(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 27'(beats[i]);
      in_neg   = negs[i];
      tick();
      if (gaps && i != n - 1) begin
        in_valid = 1'b0;
        in_data  = 27'(12345);
        tick();
      end
    end
    in_valid = 1'b0;
    in_neg   = 1'b0;
  endtask

  task automatic finish_job(input string name, input longint lit32, input longint lit8,
                            input bit lit_flag8);
    int w;
    w = 0;
    check({name, "_in_ready_done"}, in_ready, 0);
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    check({name, "_latency"}, w, 0);
    check({name, "_out32"}, out32, lit32);
    check({name, "_out8"}, out8, lit8);
`ifdef MAC_PSUM_SAT_EN
    check({name, "_sat_flag8"}, sat_flag8, lit_flag8);
`else
    if (lit_flag8) w = w;
`endif
    out_ready = 1'b1;
    tick();
    check({name, "_idle_after_accept"}, busy, 0);
  endtask

  // Per-cycle compare against the model whenever a result is presented.
  always @(negedge clk) begin
    if (reset) begin
      beat_cnt = 0;
    end else begin
      check("twin_out_valid", out_valid8, out_valid);
      if (in_valid && in_ready) beat_cnt++;
      if (out_valid) begin
        if (exp_acc.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out_valid: got out_valid=1, expected no pending job");
        end else begin
          check("model_out32", out32, reduce_to(exp_acc[0], 32));
          check("model_out8", out8, reduce_to(exp_acc[0], 8));
`ifdef MAC_PSUM_SAT_EN
          check("model_sat8", sat_flag8, longint'(sat_to(exp_acc[0], 8) != exp_acc[0]));
          check("model_sat32", sat_flag, longint'(sat_to(exp_acc[0], 32) != exp_acc[0]));
`endif
          if (out_ready) begin
            check("model_beats", beat_cnt, exp_n[0]);
            void'(exp_acc.pop_front());
            void'(exp_n.pop_front());
            beat_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected $finish before 100000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_beats = '0; bit_serial = 1'b0;
    in_valid = 1'b0; in_data = '0; in_neg = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out32, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
`ifdef MAC_PSUM_SAT_EN
    check("rst_sat_flag", sat_flag, 0);
`endif
    reset = 1'b0;
    tick();

    // in_valid while idle must be ignored
    in_valid = 1'b1; in_data = 27'(1000);
    tick(); tick(); tick();
    check("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // 1: plain sum 5,-2,7,10
    load(4, 0, 0);
    beats[0] = 5; beats[1] = -2; beats[2] = 7; beats[3] = 10;
    begin_job(4, 1'b0, 1'b1);
    feed_beats(4, 1'b0);
    finish_job("plain", 20, 20, 1'b0);

    // 2: bit-serial planes 1,0,1,1 with the sign plane negated
    load(4, 0, 0);
    beats[0] = 1; beats[1] = 0; beats[2] = 1; beats[3] = 1; negs[0] = 1'b1;
    begin_job(4, 1'b1, 1'b1);
    feed_beats(4, 1'b0);
    finish_job("serial", -5, -5, 1'b0);

    // 3: backpressure in DONE, then consume and restart in the same cycle
    load(4, 0, 0);
    beats[0] = 5; beats[1] = -2; beats[2] = 7; beats[3] = 10;
    begin_job(4, 1'b0, 1'b1);
    out_ready = 1'b0;
    feed_beats(4, 1'b0);
    in_valid = 1'b1; in_data = 27'(77);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out32, 20);
      tick();
    end
    in_valid = 1'b0;
    load(2, 0, 0);
    beats[0] = 3; beats[1] = 4;
    out_ready = 1'b1;
    begin_job(2, 1'b0, 1'b1);
    check("restart_in_ready", in_ready, 1);
    feed_beats(2, 1'b0);
    finish_job("restart", 7, 7, 1'b0);

    // 4: in_valid gaps
    load(4, 0, 0);
    beats[0] = 5; beats[1] = -2; beats[2] = 7; beats[3] = 10;
    begin_job(4, 1'b0, 1'b1);
    feed_beats(4, 1'b1);
    finish_job("gaps", 20, 20, 1'b0);

    // 5: async reset between edges mid-job
    load(3, 0, 0);
    beats[0] = 4; beats[1] = 4; beats[2] = 4;
    begin_job(3, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 27'(4);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_valid", out_valid, 0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    load(1, 0, 0);
    beats[0] = 9;
    begin_job(1, 1'b0, 1'b1);
    feed_beats(1, 1'b0);
    finish_job("after_reset", 9, 9, 1'b0);

    // 6: 8-bit output overflow, 100+100
    load(2, 0, 0);
    beats[0] = 100; beats[1] = 100;
    begin_job(2, 1'b0, 1'b1);
    feed_beats(2, 1'b0);
`ifdef MAC_PSUM_SAT_EN
    finish_job("sat", 200, 127, 1'b1);
`else
    finish_job("wrap", 200, -56, 1'b0);
`endif

    // Maximum job length: 1..16 = 136
    load(16, 1, 1);
    begin_job(16, 1'b0, 1'b1);
    feed_beats(16, 1'b0);
`ifdef MAC_PSUM_SAT_EN
    finish_job("max_beats", 136, 127, 1'b1);
`else
    finish_job("max_beats", 136, -120, 1'b0);
`endif

    // Negative clamp via bit-serial: planes -100 then 60 -> -200+60 = -140
    load(2, 0, 0);
    beats[0] = 100; beats[1] = 60; negs[0] = 1'b1;
    begin_job(2, 1'b1, 1'b1);
    feed_beats(2, 1'b0);
`ifdef MAC_PSUM_SAT_EN
    finish_job("neg_clamp", -140, -128, 1'b1);
`else
    finish_job("neg_wrap", -140, 116, 1'b0);
`endif

    tick();
    check("pending_jobs", exp_acc.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
